vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 1024, the number of visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 24, the horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 136, the horizontal sync width in clocks.
REQ-004 The block SHALL have parameter H_BACK, default 160, the horizontal back porch in clocks (H_TOTAL = 1344).
REQ-005 The block SHALL have parameter V_VISIBLE, default 768, the number of visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 3, the vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 6, the vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 29, the vertical back porch in lines (V_TOTAL = 806).
REQ-009 The block SHALL have port clk, input, 1 bit: the pixel clock (65 MHz for the defaults); it is the block's only clock.
REQ-010 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-011 The block SHALL have port hcount, output, 11 bits: the current pixel column, 0..H_TOTAL-1.
REQ-012 The block SHALL have port hsync, output, 1 bit: horizontal sync, high during the sync interval.
REQ-013 The block SHALL have port hblnk, output, 1 bit: horizontal blanking, high outside the visible columns.
REQ-014 The block SHALL have port vcount, output, 11 bits: the current line, 0..V_TOTAL-1.
REQ-015 The block SHALL have port vsync, output, 1 bit: vertical sync, high during the sync lines.
REQ-016 The block SHALL have port vblnk, output, 1 bit: vertical blanking, high outside the visible lines.
REQ-017 The block SHALL have port frame_end, output, 1 bit: a one-clock pulse on the last pixel of each frame.

Function
REQ-018 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-019 On each clock with rst low, hcount SHALL increment by 1, and SHALL wrap to 0 on the clock after hcount == H_TOTAL-1.
REQ-020 vcount SHALL increment only on the clock where hcount wraps, and SHALL wrap to 0 when it would increment from V_TOTAL-1.
REQ-021 On every clock, the flags SHALL be consistent with the hcount/vcount values presented on that same clock.
REQ-022 hblnk SHALL be 1 iff hcount >= H_VISIBLE (1024..1343).
REQ-023 hsync SHALL be 1 iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC (1048..1183).
REQ-024 vblnk SHALL be 1 iff vcount >= V_VISIBLE (768..805), including for every column of those lines.
REQ-025 vsync SHALL be 1 iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC (771..776).
REQ-026 frame_end SHALL be 1 iff hcount == H_TOTAL-1 and vcount == V_TOTAL-1, and 0 on every other clock.
REQ-027 The outputs SHALL have a fixed latency of zero relative to the counters: flags are computed from the next-count values and registered alongside them, never one clock late.
REQ-028 Counter arithmetic SHALL be 11-bit unsigned, with no overflow for any parameter set where H_TOTAL, V_TOTAL <= 2047.
REQ-029 The output sequence SHALL be period-exact: exactly H_TOTAL*V_TOTAL = 1,083,264 clocks per frame for the defaults.
REQ-030 The block SHALL not stall, has no handshake, and SHALL have no input other than clk and rst.

Reset
REQ-031 While rst is high at a clock edge, hcount, vcount, hsync, hblnk, vsync, vblnk and frame_end SHALL all be 0 on the following clock.
REQ-032 On the first clock edge after rst falls, hcount SHALL become 1 with vcount 0, so that position (0,0) is held throughout reset.
REQ-033 Reset asserted mid-frame, including mid-sync or on the frame_end clock, SHALL abort immediately: sync is dropped, no frame_end pulse is produced, and the count restarts from (0,0).
REQ-034 No output SHALL take an X value after the first reset clock.

Verification
REQ-035 The bench SHALL cover wrap: release reset and run 1344 clocks -> hcount goes 0..1343 then 0, and vcount steps 0->1 exactly at that wrap.
REQ-036 The bench SHALL cover horizontal flags: on line 0, sample hcount 1023/1024/1047/1048/1183/1184 -> hblnk 0/1/1/1/1/1 and hsync 0/0/0/1/1/0.
REQ-037 The bench SHALL cover vertical flags: vcount 767/768/770/771/776/777 -> vblnk 0/1/1/1/1/1 and vsync 0/0/0/1/1/0, with each value held for a whole line.
REQ-038 The bench SHALL cover frame period: count clocks between consecutive frame_end pulses -> exactly 1,083,264; the pulse is 1 clock wide, with hcount=1343 and vcount=805 on that clock.
REQ-039 The bench SHALL cover mid-operation reset: assert rst for 2 clocks at hcount=1100, vcount=772 (hsync and vsync both high) -> all outputs 0 the next clock, and the count resumes 0,1,2… on line 0 after release.
REQ-040 The bench SHALL cover sync counts: over one full frame, count hsync rising edges -> 806, and vsync high clocks -> 6*1344 = 8064.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA/XGA raster timing generator.
//
// Produces the pixel column and line counters together with the
// horizontal/vertical sync and blanking flags and a one-clock end-of-frame
// pulse. Every output is a register. The flags are decoded from the
// next-count values and registered in the same edge as the counters, so the
// flags always describe the position shown on the same clock.
//
// Ports:
//   clk       in   pixel clock (only clock)
//   rst       in   synchronous, active-high reset; holds position (0,0)
//   hcount    out  11-bit pixel column, 0..H_TOTAL-1
//   hsync     out  high during the horizontal sync interval
//   hblnk     out  high outside the visible columns
//   vcount    out  11-bit line number, 0..V_TOTAL-1
//   vsync     out  high during the vertical sync lines
//   vblnk     out  high outside the visible lines
//   frame_end out  one-clock pulse on the last pixel of each frame
module vga_timing #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        frame_end
);

    // Region boundaries as 11-bit constants so every compare is unsigned
    // and width-matched with the counters.
    localparam logic [10:0] H_LAST     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] hcount_nxt;
    logic [10:0] vcount_nxt;
    logic        hsync_nxt;
    logic        hblnk_nxt;
    logic        vsync_nxt;
    logic        vblnk_nxt;
    logic        frame_end_nxt;

    // Next position and the flags that belong to it.
    always_comb begin
        hcount_nxt = hcount + 11'd1;
        vcount_nxt = vcount;
        if (hcount == H_LAST) begin
            hcount_nxt = '0;
            if (vcount == V_LAST) begin
                vcount_nxt = '0;
            end else begin
                vcount_nxt = vcount + 11'd1;
            end
        end

        hblnk_nxt     = (hcount_nxt >= H_VIS_END);
        hsync_nxt     = (hcount_nxt >= H_SYNC_BEG) && (hcount_nxt < H_SYNC_END);
        vblnk_nxt     = (vcount_nxt >= V_VIS_END);
        vsync_nxt     = (vcount_nxt >= V_SYNC_BEG) && (vcount_nxt < V_SYNC_END);
        frame_end_nxt = (hcount_nxt == H_LAST) && (vcount_nxt == V_LAST);
    end

    // Output registers. Reset parks the raster at (0,0) with every flag low,
    // which drops any sync in progress and suppresses a pending frame_end.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount    <= '0;
            vcount    <= '0;
            hsync     <= 1'b0;
            hblnk     <= 1'b0;
            vsync     <= 1'b0;
            vblnk     <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            hcount    <= hcount_nxt;
            vcount    <= vcount_nxt;
            hsync     <= hsync_nxt;
            hblnk     <= hblnk_nxt;
            vsync     <= vsync_nxt;
            vblnk     <= vblnk_nxt;
            frame_end <= frame_end_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: self-checking bench for vga_timing.
// The DUT is built with a reduced raster (same porch/sync structure,
// shorter lines and frame) so that several whole frames fit in a short run.
module tb_vga_timing;

    localparam int HV = 64;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 12;
    localparam int VV = 48;
    localparam int VF = 3;
    localparam int VS = 6;
    localparam int VB = 5;
    localparam int HT  = HV + HF + HS + HB;   // 88
    localparam int VT  = VV + VF + VS + VB;   // 62
    localparam int HSS = HV + HF;             // 68
    localparam int HSE = HV + HF + HS;        // 76
    localparam int VSS = VV + VF;             // 51
    localparam int VSE = VV + VF + VS;        // 57

    // Boundary samples: last visible, first blank, last front porch,
    // first sync, last sync, first back porch.
    localparam int HPTS[6]   = '{HV - 1, HV, HSS - 1, HSS, HSE - 1, HSE};
    localparam int HB_EXP[6] = '{0, 1, 1, 1, 1, 1};
    localparam int HS_EXP[6] = '{0, 0, 0, 1, 1, 0};
    localparam int VPTS[6]   = '{VV - 1, VV, VSS - 1, VSS, VSE - 1, VSE};
    localparam int VB_EXP[6] = '{0, 1, 1, 1, 1, 1};
    localparam int VS_EXP[6] = '{0, 0, 0, 1, 1, 0};

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic        fe;
    } out_t;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic        frame_end;

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hcount   (hcount),
        .hsync    (hsync),
        .hblnk    (hblnk),
        .vcount   (vcount),
        .vsync    (vsync),
        .vblnk    (vblnk),
        .frame_end(frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    int   mh = 0;
    int   mv = 0;
    int   cyc = 0;
    int   last_fe = 0;
    int   fe_seen = 0;
    int   fe_interval = 0;
    int   hs_rise = 0;
    int   vs_high = 0;
    int   fe_hs = 0;
    int   fe_vs = 0;
    logic prev_hs = 1'b0;

    function automatic out_t model(input int h, input int v);
        out_t e;
        e.h  = 11'(h);
        e.v  = 11'(v);
        e.hb = (h >= HV);
        e.hs = (h >= HSS) && (h < HSE);
        e.vb = (v >= VV);
        e.vs = (v >= VSS) && (v < VSE);
        e.fe = (h == HT - 1) && (v == VT - 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: push the expected outputs, clock, pop and compare.
    task automatic tick(input logic r);
        out_t e;
        out_t o;
        rst = r;
        if (r) begin
            mh = 0;
            mv = 0;
            e  = '0;
        end else begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            e = model(mh, mv);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        o = {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_end};
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL scoreboard cyc=%0d observed %h expected %h", cyc, o, e);
        end
        if (!r) begin
            if (hsync === 1'b1 && prev_hs !== 1'b1) hs_rise++;
            if (vsync === 1'b1) vs_high++;
            if (frame_end === 1'b1) begin
                fe_seen++;
                fe_interval = cyc - last_fe;
                last_fe = cyc;
                fe_hs = hs_rise;
                fe_vs = vs_high;
                hs_rise = 0;
                vs_high = 0;
            end
        end
        prev_hs = hsync;
    endtask

    task automatic run_to(input int h, input int v, input int budget, input string tag);
        int n;
        n = 0;
        while (!(hcount == 11'(h) && vcount == 11'(v)) && n < budget) begin
            tick(1'b0);
            n++;
        end
        chk(tag, {31'd0, (hcount == 11'(h) && vcount == 11'(v))}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_h"}, 32'(hcount), 32'd0);
        chk({tag, "_v"}, 32'(vcount), 32'd0);
        chk({tag, "_flags"}, {27'd0, hsync, hblnk, vsync, vblnk, frame_end}, 32'd0);
    endtask

    initial begin
        int hhits;
        int vhits;
        int n;
        int fe0;
        rst = 1'b1;

        // Reset state
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        chk_all_zero("reset");

        // Release: first edge goes to column 1 of line 0
        tick(1'b0);
        chk("rel_h", 32'(hcount), 32'd1);
        chk("rel_v", 32'(vcount), 32'd0);

        // Line 0: horizontal flag boundaries, then the wrap
        hhits = 0;
        for (int i = 0; i < HT - 2; i++) begin
            tick(1'b0);
            for (int k = 0; k < 6; k++) begin
                if (hcount == 11'(HPTS[k])) begin
                    chk("hblnk_pt", 32'(hblnk), 32'(HB_EXP[k]));
                    chk("hsync_pt", 32'(hsync), 32'(HS_EXP[k]));
                    hhits++;
                end
            end
        end
        chk("hpt_hits", 32'(hhits), 32'd6);
        chk("pre_wrap_h", 32'(hcount), 32'(HT - 1));
        chk("pre_wrap_v", 32'(vcount), 32'd0);
        tick(1'b0);
        chk("wrap_h", 32'(hcount), 32'd0);
        chk("wrap_v", 32'(vcount), 32'd1);

        // First frame end with vertical flag boundaries (first and last column)
        vhits = 0;
        n = 0;
        fe0 = fe_seen;
        while (fe_seen == fe0 && n < HT * VT + 10) begin
            tick(1'b0);
            n++;
            for (int k = 0; k < 6; k++) begin
                if (vcount == 11'(VPTS[k]) && (hcount == 11'd0 || hcount == 11'(HT - 1))) begin
                    chk("vblnk_pt", 32'(vblnk), 32'(VB_EXP[k]));
                    chk("vsync_pt", 32'(vsync), 32'(VS_EXP[k]));
                    vhits++;
                end
            end
        end
        chk("frame1_seen", 32'(fe_seen), 32'(fe0 + 1));
        chk("vpt_hits", 32'(vhits), 32'd12);
        chk("fe_h", 32'(hcount), 32'(HT - 1));
        chk("fe_v", 32'(vcount), 32'(VT - 1));

        // One full frame: period, pulse width, sync counts
        n = 0;
        fe0 = fe_seen;
        while (fe_seen == fe0 && n < HT * VT + 10) begin
            tick(1'b0);
            n++;
        end
        chk("frame2_seen", 32'(fe_seen), 32'(fe0 + 1));
        chk("frame_period", 32'(fe_interval), 32'(HT * VT));
        chk("hsync_rises", 32'(fe_hs), 32'(VT));
        chk("vsync_high", 32'(fe_vs), 32'(VS * HT));
        tick(1'b0);
        chk("fe_width", 32'(frame_end), 32'd0);
        chk("after_fe_h", 32'(hcount), 32'd0);
        chk("after_fe_v", 32'(vcount), 32'd0);

        // Reset in the middle of both syncs
        run_to(HSS + HS / 2, VSS + 1, HT * VT + 10, "reach_mid");
        chk("mid_hsync", 32'(hsync), 32'd1);
        chk("mid_vsync", 32'(vsync), 32'd1);
        tick(1'b1);
        chk_all_zero("midrst1");
        tick(1'b1);
        chk_all_zero("midrst2");
        for (int i = 1; i <= 3; i++) begin
            tick(1'b0);
            chk("resume_h", 32'(hcount), 32'(i));
            chk("resume_v", 32'(vcount), 32'd0);
        end

        // Reset landing on the frame_end clock
        run_to(HT - 1, VT - 1, HT * VT + 10, "reach_fe");
        chk("fe_before_rst", 32'(frame_end), 32'd1);
        tick(1'b1);
        chk_all_zero("ferst");
        tick(1'b0);
        chk("ferst_resume_h", 32'(hcount), 32'd1);
        chk("ferst_resume_v", 32'(vcount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
